// File: rtl/add_sched_if.sv
// Bundle of requester, shared-adder and result signals for add_sched.
// master is the scheduler side, slave is the surrounding environment.
interface add_sched_if #(
   parameter int unsigned NWORDS = 4
);
   localparam int unsigned W = 16 * NWORDS;

   logic          req0;
   logic [W-1:0]  A0;
   logic [W-1:0]  B0;
   logic          Cin0;
   logic          req1;
   logic [W-1:0]  A1;
   logic [W-1:0]  B1;
   logic          Cin1;
   logic          gnt0;
   logic          gnt1;
   logic [15:0]   add_A;
   logic [15:0]   add_B;
   logic          add_Cin;
   logic [15:0]   add_S;
   logic          add_Cout;
   logic [W-1:0]  res;
   logic          res_cout;
   logic          res_id;
   logic          res_valid;
   logic          res_ready;

   modport master (
      input  req0, A0, B0, Cin0, req1, A1, B1, Cin1, add_S, add_Cout, res_ready,
      output gnt0, gnt1, add_A, add_B, add_Cin, res, res_cout, res_id, res_valid
   );

   modport slave (
      output req0, A0, B0, Cin0, req1, A1, B1, Cin1, add_S, add_Cout, res_ready,
      input  gnt0, gnt1, add_A, add_B, add_Cin, res, res_cout, res_id, res_valid
   );
endinterface

// File: rtl/add_sched.sv
// Two-requester scheduler that walks a wide addition word by word through an
// external shared 16-bit adder, waiting SETTLE cycles for each word to settle.
module add_sched #(
   parameter int unsigned NWORDS = 4,
   parameter int unsigned SETTLE = 3
) (
   input  logic       clk,
   input  logic       rst,
   add_sched_if.master bus
);
   localparam int unsigned KW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

   typedef enum logic [1:0] {IDLE, WAIT, CAP, OUT} state_t;

   state_t                    state;
   logic [NWORDS-1:0][15:0]   opa;
   logic [NWORDS-1:0][15:0]   opb;
   logic [NWORDS-1:0][15:0]   resw;
   logic [KW-1:0]             k;
   logic [3:0]                cnt;
   logic                      last;
   logic                      win;

   // Round-robin pick: a lone requester wins, a tie goes to the one not granted last.
   always_comb begin
      win = bus.req1;
      if (bus.req0 && bus.req1) win = ~last;
   end

   assign bus.gnt0 = (state == IDLE) && bus.req0 && !win;
   assign bus.gnt1 = (state == IDLE) && bus.req1 && win;
   assign bus.res  = resw;

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         opa           <= '0;
         opb           <= '0;
         resw          <= '0;
         k             <= '0;
         cnt           <= '0;
         last          <= 1'b1;
         bus.add_A     <= '0;
         bus.add_B     <= '0;
         bus.add_Cin   <= 1'b0;
         bus.res_cout  <= 1'b0;
         bus.res_id    <= 1'b0;
         bus.res_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req0 || bus.req1) begin
                  opa         <= win ? bus.A1 : bus.A0;
                  opb         <= win ? bus.B1 : bus.B0;
                  bus.add_A   <= win ? bus.A1[15:0] : bus.A0[15:0];
                  bus.add_B   <= win ? bus.B1[15:0] : bus.B0[15:0];
                  bus.add_Cin <= win ? bus.Cin1 : bus.Cin0;
                  bus.res_id  <= win;
                  last        <= win;
                  k           <= '0;
                  cnt         <= '0;
                  state       <= WAIT;
               end
            end
            WAIT: begin
               if (cnt == 4'(SETTLE - 1)) state <= CAP;
               else                       cnt   <= cnt + 4'd1;
            end
            CAP: begin
               resw[k] <= bus.add_S;
               if (k == KW'(NWORDS - 1)) begin
                  bus.res_cout  <= bus.add_Cout;
                  bus.res_valid <= 1'b1;
                  bus.add_A     <= '0;
                  bus.add_B     <= '0;
                  bus.add_Cin   <= 1'b0;
                  state         <= OUT;
               end else begin
                  // Next word goes out with this word's carry chained in.
                  k           <= k + KW'(1);
                  cnt         <= '0;
                  bus.add_A   <= opa[k + KW'(1)];
                  bus.add_B   <= opb[k + KW'(1)];
                  bus.add_Cin <= bus.add_Cout;
                  state       <= WAIT;
               end
            end
            OUT: begin
               if (bus.res_ready) begin
                  bus.res_valid <= 1'b0;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_add_sched.sv
// Self-checking bench for add_sched: table-driven operations, arbitration,
// back-pressure, mid-operation reset and a SETTLE=1 latency instance.
module tb_add_sched;
   localparam int unsigned NW = 4;

   typedef struct packed {
      logic [63:0] res;
      logic        cout;
      logic        id;
   } exp_t;

   typedef struct {
      logic        id;
      logic [63:0] a;
      logic [63:0] b;
      logic        cin;
      logic [63:0] res;
      logic        cout;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   add_sched_if #(.NWORDS(NW)) bus  ();
   add_sched_if #(.NWORDS(NW)) bus2 ();

   add_sched #(.NWORDS(NW), .SETTLE(3)) dut  (.clk(clk), .rst(rst), .bus(bus));
   add_sched #(.NWORDS(NW), .SETTLE(1)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

   // Shared 16-bit adders sitting outside each scheduler.
   assign {bus.add_Cout, bus.add_S}   = 17'(bus.add_A) + 17'(bus.add_B) + 17'(bus.add_Cin);
   assign {bus2.add_Cout, bus2.add_S} = 17'(bus2.add_A) + 17'(bus2.add_B) + 17'(bus2.add_Cin);

   exp_t        q[$];
   int          gnt_log[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          gnt_cyc = 0;
   int          done_cnt = 0;
   bit          busy = 0;
   logic        prev_valid = 1'b0;
   logic        prev_ready = 1'b0;
   logic [63:0] prev_res = '0;
   logic        prev_cout = 1'b0;
   logic        prev_id = 1'b0;
   exp_t        cur_exp0;
   exp_t        cur_exp1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: push on grant, pop on accepted result.
   always @(negedge clk) begin
      exp_t e;
      cyc++;
      if (rst) begin
         q.delete();
         busy       = 0;
         prev_valid = 1'b0;
      end else begin
         if (bus.gnt0 || bus.gnt1) begin
            chk("gnt_exclusive", 64'(bus.gnt0 && bus.gnt1), 64'(0));
            chk("gnt_only_idle", 64'(busy), 64'(0));
            busy    = 1;
            gnt_cyc = cyc;
            gnt_log.push_back(bus.gnt1 ? 1 : 0);
            q.push_back(bus.gnt1 ? cur_exp1 : cur_exp0);
         end
         if (bus.res_valid && !prev_valid)
            chk("latency", 64'(cyc - gnt_cyc), 64'(17));
         if (bus.res_valid && prev_valid && !prev_ready) begin
            chk("res_hold", bus.res, prev_res);
            chk("cout_hold", 64'(bus.res_cout), 64'(prev_cout));
            chk("id_hold", 64'(bus.res_id), 64'(prev_id));
         end
         if (bus.res_valid && bus.res_ready) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_result: got res %h with no operation outstanding", bus.res);
            end else begin
               e = q.pop_front();
               chk("res", bus.res, e.res);
               chk("res_cout", 64'(bus.res_cout), 64'(e.cout));
               chk("res_id", 64'(bus.res_id), 64'(e.id));
            end
            busy = 0;
            done_cnt++;
         end
         prev_valid = bus.res_valid;
         prev_ready = bus.res_ready;
         prev_res   = bus.res;
         prev_cout  = bus.res_cout;
         prev_id    = bus.res_id;
      end
   end

   task automatic run_op(input logic id, input logic [63:0] a, input logic [63:0] b,
                         input logic cin, input logic [63:0] er, input logic ec);
      int n;
      int start;
      @(posedge clk); #1;
      if (id) begin
         bus.A1 = a; bus.B1 = b; bus.Cin1 = cin; cur_exp1 = '{er, ec, 1'b1}; bus.req1 = 1'b1;
      end else begin
         bus.A0 = a; bus.B0 = b; bus.Cin0 = cin; cur_exp0 = '{er, ec, 1'b0}; bus.req0 = 1'b1;
      end
      start = done_cnt;
      n = 0;
      @(negedge clk); #1;
      while (!(id ? bus.gnt1 : bus.gnt0) && n < 40) begin @(negedge clk); #1; n++; end
      chk("gnt_wait", 64'(n < 40), 64'(1));
      @(posedge clk); #1;
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      n = 0;
      while (done_cnt == start && n < 80) begin @(negedge clk); #1; n++; end
      chk("done_wait", 64'(n < 80), 64'(1));
   endtask

   task automatic do_reset();
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
   endtask

   vec_t vecs[6];

   initial begin
      int          n;
      int          start;
      int          nvalid;
      logic [63:0] ra;
      logic [63:0] rb;
      logic        rc;
      logic [63:0] rs;
      logic        rco;

      vecs[0] = '{1'b0, 64'h0000_0000_0000_24D7, 64'h0000_0000_0000_03F8, 1'b0, 64'h0000_0000_0000_28CF, 1'b0};
      vecs[1] = '{1'b1, 64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_0001, 1'b0, 64'h0000_0000_0001_0000, 1'b0};
      vecs[2] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0000, 1'b1, 64'h0000_0000_0000_0000, 1'b1};
      vecs[3] = '{1'b1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0000_0000_0000_0000, 1'b1};
      vecs[4] = '{1'b0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 64'h2222_2222_2222_2212, 1'b0};
      vecs[5] = '{1'b1, 64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, 64'h0001_0000_0001_0000, 1'b0};

      rst = 1'b1;
      bus.req0 = 0; bus.A0 = '0; bus.B0 = '0; bus.Cin0 = 0;
      bus.req1 = 0; bus.A1 = '0; bus.B1 = '0; bus.Cin1 = 0;
      bus.res_ready = 1'b1;
      bus2.req0 = 0; bus2.A0 = '0; bus2.B0 = '0; bus2.Cin0 = 0;
      bus2.req1 = 0; bus2.A1 = '0; bus2.B1 = '0; bus2.Cin1 = 0;
      bus2.res_ready = 1'b1;
      cur_exp0 = '0;
      cur_exp1 = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state
      @(negedge clk); #1;
      chk("rst_add_A", 64'(bus.add_A), 64'(0));
      chk("rst_add_B", 64'(bus.add_B), 64'(0));
      chk("rst_add_Cin", 64'(bus.add_Cin), 64'(0));
      chk("rst_res", bus.res, 64'(0));
      chk("rst_res_cout", 64'(bus.res_cout), 64'(0));
      chk("rst_res_id", 64'(bus.res_id), 64'(0));
      chk("rst_res_valid", 64'(bus.res_valid), 64'(0));
      chk("rst_gnt", 64'({bus.gnt0, bus.gnt1}), 64'(0));

      foreach (vecs[i])
         run_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].res, vecs[i].cout);

      for (int i = 0; i < 3; i++) begin
         ra = {$urandom, $urandom};
         rb = {$urandom, $urandom};
         rc = 1'($urandom_range(0, 1));
         {rco, rs} = 65'(ra) + 65'(rb) + 65'(rc);
         run_op(i[0], ra, rb, rc, rs, rco);
      end

      // Both requesters out of reset: order 0, 1, 0
      do_reset();
      gnt_log.delete();
      @(posedge clk); #1;
      bus.A0 = 64'h1111; bus.B0 = 64'h2222; bus.Cin0 = 0;
      cur_exp0 = '{64'h3333, 1'b0, 1'b0};
      bus.A1 = 64'hFFFF_0000_0000_0000; bus.B1 = 64'h0001_0000_0000_0000; bus.Cin1 = 0;
      cur_exp1 = '{64'h0, 1'b1, 1'b1};
      start = done_cnt;
      bus.req0 = 1; bus.req1 = 1;
      n = 0;
      while (gnt_log.size() < 3 && n < 200) begin @(negedge clk); #1; n++; end
      @(posedge clk); #1;
      bus.req0 = 0; bus.req1 = 0;
      n = 0;
      while (done_cnt < start + 3 && n < 100) begin @(negedge clk); #1; n++; end
      chk("rr_done_wait", 64'(n < 100), 64'(1));
      chk("rr_count", 64'(gnt_log.size()), 64'(3));
      chk("rr_order0", 64'(gnt_log.size() > 0 ? gnt_log[0] : -1), 64'(0));
      chk("rr_order1", 64'(gnt_log.size() > 1 ? gnt_log[1] : -1), 64'(1));
      chk("rr_order2", 64'(gnt_log.size() > 2 ? gnt_log[2] : -1), 64'(0));

      // Back-pressure in OUT with req1 pending
      @(posedge clk); #1;
      bus.res_ready = 0;
      bus.A0 = 64'h0000_0000_ABCD_0001; bus.B0 = 64'h0000_0000_1111_FFFF; bus.Cin0 = 0;
      cur_exp0 = '{64'h0000_0000_BCDF_0000, 1'b0, 1'b0};
      bus.req0 = 1;
      n = 0;
      @(negedge clk); #1;
      while (!bus.gnt0 && n < 40) begin @(negedge clk); #1; n++; end
      chk("bp_gnt_wait", 64'(n < 40), 64'(1));
      @(posedge clk); #1;
      bus.req0 = 0;
      bus.A1 = 64'h5; bus.B1 = 64'h6; bus.Cin1 = 1;
      cur_exp1 = '{64'hC, 1'b0, 1'b1};
      bus.req1 = 1;
      n = 0;
      while (!bus.res_valid && n < 40) begin @(negedge clk); #1; n++; end
      chk("bp_valid_wait", 64'(n < 40), 64'(1));
      repeat (5) begin @(negedge clk); #1; end
      chk("bp_valid_held", 64'(bus.res_valid), 64'(1));
      @(posedge clk); #1;
      bus.res_ready = 1;
      @(negedge clk); #1;
      chk("bp_no_gnt_in_out", 64'(bus.gnt1), 64'(0));
      start = done_cnt;
      @(negedge clk); #1;
      chk("bp_gnt_after_out", 64'(bus.gnt1), 64'(1));
      @(posedge clk); #1;
      bus.req1 = 0;
      n = 0;
      while (done_cnt == start && n < 80) begin @(negedge clk); #1; n++; end
      chk("bp_done_wait", 64'(n < 80), 64'(1));

      // Reset at cycle 8 of an operation
      @(posedge clk); #1;
      bus.A0 = 64'h1111_2222_3333_4444; bus.B0 = 64'h0101_0101_0101_0101; bus.Cin0 = 0;
      cur_exp0 = '{64'h1212_2323_3434_4545, 1'b0, 1'b0};
      bus.req0 = 1;
      n = 0;
      @(negedge clk); #1;
      while (!bus.gnt0 && n < 40) begin @(negedge clk); #1; n++; end
      chk("mr_gnt_wait", 64'(n < 40), 64'(1));
      @(posedge clk); #1;
      bus.req0 = 0;
      repeat (7) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk); #1;
      chk("mr_word1_presented", 64'(bus.add_A), 64'(16'h3333));
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk); #1;
      chk("mr_add_A", 64'(bus.add_A), 64'(0));
      chk("mr_add_B", 64'(bus.add_B), 64'(0));
      chk("mr_add_Cin", 64'(bus.add_Cin), 64'(0));
      chk("mr_res", bus.res, 64'(0));
      chk("mr_res_cout_id", 64'({bus.res_cout, bus.res_id}), 64'(0));
      chk("mr_res_valid", 64'(bus.res_valid), 64'(0));
      chk("mr_gnt", 64'({bus.gnt0, bus.gnt1}), 64'(0));
      nvalid = 0;
      repeat (30) begin @(negedge clk); #1; if (bus.res_valid) nvalid++; end
      chk("mr_no_valid", 64'(nvalid), 64'(0));

      // SETTLE=1 instance latency
      @(posedge clk); #1;
      bus2.A0 = 64'h24D7; bus2.B0 = 64'h03F8; bus2.Cin0 = 0;
      bus2.req0 = 1;
      n = 0;
      @(negedge clk); #1;
      while (!bus2.gnt0 && n < 40) begin @(negedge clk); #1; n++; end
      chk("s1_gnt_wait", 64'(n < 40), 64'(1));
      @(posedge clk); #1;
      bus2.req0 = 0;
      n = 0;
      do begin @(negedge clk); #1; n++; end while (!bus2.res_valid && n < 40);
      chk("s1_latency", 64'(n), 64'(9));
      chk("s1_res", bus2.res, 64'h28CF);
      chk("s1_res_id", 64'(bus2.res_id), 64'(0));

      repeat (2) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      checks++;
      errors++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/add_sched.md
ADD_SCHED -- requirements
Module: add_sched

Interface
REQ-001 Parameter NWORDS, default 4, number of 16-bit words per operation (operand width W = 16*NWORDS).
REQ-002 Parameter SETTLE, default 3, wait cycles allowed after new adder inputs before the sum is sampled; legal range 1..15.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 req0  in  1  requester 0 operation request, level, held until gnt0.
REQ-006 A0, B0  in  W each  requester 0 operands, valid while req0 high.
REQ-007 Cin0  in  1  requester 0 carry-in.
REQ-008 req1, A1, B1, Cin1  in  1/W/W/1  requester 1, same rules as REQ-005..007.
REQ-009 gnt0, gnt1  out  1 each  combinational accept strobe; operands are captured on the edge ending the gnt cycle.
REQ-010 add_A, add_B  out  16 each  registered operand word driven to the shared 16-bit adder.
REQ-011 add_Cin  out  1  registered carry-in driven to the shared adder.
REQ-012 add_S  in  16, add_Cout  in  1  shared adder sum and carry-out.
REQ-013 res  out  W  assembled sum; res_cout  out  1  final carry; res_id  out  1  owning requester.
REQ-014 res_valid  out  1  result valid; res_ready  in  1  consumer accept.

Function
REQ-015 FSM states SHALL be IDLE, WAIT, CAP, OUT.
REQ-016 IDLE: if any req is high, exactly one gnt SHALL be high that cycle; the FSM latches that requester's operands, Cin and id, sets word index k=0, and goes to WAIT.
REQ-017 Arbitration SHALL be round-robin: a single requester wins immediately; when both request, the requester not granted last wins; after reset req0 wins a tie.
REQ-018 gnt SHALL be low in every state except IDLE; a req dropped before its gnt has no effect.
REQ-019 WAIT: add_A/add_B SHALL present word k of the latched operands (bits 16k+15..16k); add_Cin SHALL be latched Cin for k=0, else the carry captured from word k-1.
REQ-020 WAIT SHALL last exactly SETTLE cycles, counted from the first cycle word k is presented, then go to CAP.
REQ-021 CAP (1 cycle, inputs unchanged): add_S SHALL be written to res word k and add_Cout stored as the running carry; if k=NWORDS-1, go to OUT with res_cout = add_Cout, else k=k+1 and go to WAIT.
REQ-022 Latency: with the gnt cycle as cycle 0, word k SHALL be captured at cycle (k+1)*(SETTLE+1), and res_valid SHALL first be high at cycle NWORDS*(SETTLE+1)+1 (17 with defaults).
REQ-023 OUT: res_valid SHALL be high and res, res_cout, res_id stable until a cycle with res_ready high; the FSM then returns to IDLE, and no gnt is issued in that same cycle.
REQ-024 add_A, add_B and add_Cin SHALL be 0 in IDLE and OUT.
REQ-025 The block performs no arithmetic itself; the result is exactly the concatenation of the adder outputs, modulo 2^W, with carry out in res_cout.

Reset
REQ-026 On rst the block SHALL go to IDLE and clear gnt0/1, res, res_cout, res_id, res_valid, add_A, add_B, add_Cin, k and the settle counter; the round-robin pointer SHALL favour req0.
REQ-027 Reset mid-operation SHALL abandon the operation; no res_valid is produced for it, and the requester must re-request.

Verification
REQ-028 req0, A0=0x0000_0000_0000_24D7, B0=0x0000_0000_0000_03F8, Cin0=0 -> gnt0 at cycle 0, res_valid at cycle 17, res=0x0000_0000_0000_28CF, res_cout=0, res_id=0.
REQ-029 req1, A1=0x0000_0000_0000_FFFF, B1=0x1, Cin1=0 -> res=0x0000_0000_0001_0000 (carry crosses a word boundary), res_id=1; A=0xFFFF_FFFF_FFFF_FFFF, B=0, Cin=1 -> res=0, res_cout=1.
REQ-030 req0 and req1 both high out of reset with res_ready=1 -> grant order req0, req1, req0; each gnt appears only in IDLE.
REQ-031 res_ready low for 5 cycles in OUT -> res_valid and res held stable, no gnt while a req is pending, return to IDLE the cycle after res_ready rises.
REQ-032 rst asserted at cycle 8 of an operation -> all outputs 0 the next cycle and no res_valid follows; SETTLE=1 with NWORDS=4 -> res_valid at cycle 9.
